// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, multi-cycle mul/div, memory-wait stalls and branch flushes.
// Optional performance counters are enabled with the HAZARD_CTRL_PERF_EN macro.
module hazard_ctrl #(
  parameter int MDIV_CYCLES = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] d_rs1_i,
  input  logic [4:0] d_rs2_i,
  input  logic       d_rs1_used_i,
  input  logic       d_rs2_used_i,
  input  logic [4:0] e_rd_i,
  input  logic       e_load_i,
  input  logic       e_branch_taken_i,
  input  logic       e_mdiv_start_i,
  input  logic       m_mem_req_i,
  input  logic       m_mem_ready_i,
  output logic       f_stall_o,
  output logic       d_stall_o,
  output logic       e_stall_o,
  output logic       m_stall_o,
  output logic       w_stall_o,
  output logic       fd_flush_o,
  output logic       de_flush_o,
  output logic       em_flush_o,
  output logic       mw_flush_o,
`ifdef HAZARD_CTRL_PERF_EN
  output logic [31:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o,
`endif
  output logic       e_mdiv_done_o
);

  localparam int CNT_W = $clog2(MDIV_CYCLES);

  typedef enum logic {RUN, MDIV} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] mdiv_cnt_q, mdiv_cnt_d;

  logic mem_wait;
  logic load_use;
  logic mdiv_busy;
  logic e_hold;
  logic br_flush;
  logic lu_stall;

  always_comb begin
    mem_wait = m_mem_req_i & ~m_mem_ready_i;
    load_use = e_load_i & (e_rd_i != 5'd0) &
               ((d_rs1_used_i & (d_rs1_i == e_rd_i)) |
                (d_rs2_used_i & (d_rs2_i == e_rd_i)));
    // E is held on the start cycle and on every counting cycle; the cnt==0 cycle releases it.
    mdiv_busy = ((state_q == RUN) & e_mdiv_start_i & ~mem_wait) |
                ((state_q == MDIV) & (mdiv_cnt_q != '0));
    e_hold    = mem_wait | mdiv_busy;
    br_flush  = e_branch_taken_i & ~e_hold;
    lu_stall  = load_use & ~mem_wait & ~br_flush;
  end

  always_comb begin
    state_d    = state_q;
    mdiv_cnt_d = mdiv_cnt_q;
    if (rst_i) begin
      state_d    = RUN;
      mdiv_cnt_d = '0;
    end else if (state_q == RUN) begin
      if (e_mdiv_start_i & ~mem_wait) begin
        state_d    = MDIV;
        mdiv_cnt_d = CNT_W'(MDIV_CYCLES - 1);
      end
    end else if (mdiv_cnt_q != '0) begin
      mdiv_cnt_d = mdiv_cnt_q - CNT_W'(1);
    end else begin
      state_d = RUN;
    end
  end

  // Outputs are forced low while reset is asserted.
  always_comb begin
    f_stall_o     = 1'b0;
    d_stall_o     = 1'b0;
    e_stall_o     = 1'b0;
    m_stall_o     = 1'b0;
    w_stall_o     = 1'b0;
    fd_flush_o    = 1'b0;
    de_flush_o    = 1'b0;
    em_flush_o    = 1'b0;
    mw_flush_o    = 1'b0;
    e_mdiv_done_o = 1'b0;
    if (!rst_i) begin
      f_stall_o     = e_hold | lu_stall;
      d_stall_o     = e_hold | lu_stall;
      e_stall_o     = e_hold;
      m_stall_o     = mem_wait;
      fd_flush_o    = br_flush;
      de_flush_o    = br_flush | lu_stall;
      em_flush_o    = mdiv_busy & ~mem_wait;
      mw_flush_o    = mem_wait;
      e_mdiv_done_o = (state_q == MDIV) & (mdiv_cnt_q == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    state_q    <= state_d;
    mdiv_cnt_q <= mdiv_cnt_d;
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (rst_i) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (f_stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
      if (fd_flush_o && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for single-cycle hazards plus
// hand-written mul/div, memory-wait, branch-hold and reset-abort sequences.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1u;
    logic       rs2u;
    logic [4:0] rd;
    logic       ld;
    logic       br;
    logic       md;
    logic       req;
    logic       rdy;
  } in_t;

  typedef struct {
    in_t        in;
    logic [9:0] exp;
    string      name;
  } vec_t;

  // Output order: f d e m w | fd de em mw | done
  localparam logic [9:0] Z    = 10'b00000_0000_0;
  localparam logic [9:0] LU   = 10'b11000_0100_0;
  localparam logic [9:0] BR   = 10'b00000_1100_0;
  localparam logic [9:0] MW   = 10'b11110_0001_0;
  localparam logic [9:0] MD   = 10'b11100_0010_0;
  localparam logic [9:0] DN   = 10'b00000_0000_1;
  localparam logic [9:0] DNBR = 10'b00000_1100_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_i;
  logic [4:0] d_rs1_i, d_rs2_i, e_rd_i;
  logic       d_rs1_used_i, d_rs2_used_i;
  logic       e_load_i, e_branch_taken_i, e_mdiv_start_i;
  logic       m_mem_req_i, m_mem_ready_i;
  logic       f_stall_o, d_stall_o, e_stall_o, m_stall_o, w_stall_o;
  logic       fd_flush_o, de_flush_o, em_flush_o, mw_flush_o;
  logic       e_mdiv_done_o;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;
  logic [31:0] sbase;
  logic [15:0] fbase;
`endif

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.MDIV_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .d_rs1_i(d_rs1_i), .d_rs2_i(d_rs2_i),
    .d_rs1_used_i(d_rs1_used_i), .d_rs2_used_i(d_rs2_used_i),
    .e_rd_i(e_rd_i), .e_load_i(e_load_i),
    .e_branch_taken_i(e_branch_taken_i), .e_mdiv_start_i(e_mdiv_start_i),
    .m_mem_req_i(m_mem_req_i), .m_mem_ready_i(m_mem_ready_i),
    .f_stall_o(f_stall_o), .d_stall_o(d_stall_o), .e_stall_o(e_stall_o),
    .m_stall_o(m_stall_o), .w_stall_o(w_stall_o),
    .fd_flush_o(fd_flush_o), .de_flush_o(de_flush_o),
    .em_flush_o(em_flush_o), .mw_flush_o(mw_flush_o),
`ifdef HAZARD_CTRL_PERF_EN
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
`endif
    .e_mdiv_done_o(e_mdiv_done_o)
  );

  wire [9:0] outv = {f_stall_o, d_stall_o, e_stall_o, m_stall_o, w_stall_o,
                     fd_flush_o, de_flush_o, em_flush_o, mw_flush_o, e_mdiv_done_o};

  function automatic in_t mk(logic rst, logic [4:0] rs1, logic [4:0] rs2, logic rs1u,
                             logic rs2u, logic [4:0] rd, logic ld, logic br, logic md,
                             logic req, logic rdy);
    in_t t;
    t.rst = rst; t.rs1 = rs1; t.rs2 = rs2; t.rs1u = rs1u; t.rs2u = rs2u;
    t.rd = rd; t.ld = ld; t.br = br; t.md = md; t.req = req; t.rdy = rdy;
    return t;
  endfunction

  function automatic in_t idle();
    return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, compare shortly after.
  task automatic cyc(input in_t t, input logic [9:0] exp, input string name);
    @(negedge clk);
    rst_i = t.rst; d_rs1_i = t.rs1; d_rs2_i = t.rs2;
    d_rs1_used_i = t.rs1u; d_rs2_used_i = t.rs2u; e_rd_i = t.rd;
    e_load_i = t.ld; e_branch_taken_i = t.br; e_mdiv_start_i = t.md;
    m_mem_req_i = t.req; m_mem_ready_i = t.rdy;
    #1;
    check(name, {22'd0, outv}, {22'd0, exp});
    check({name, "_em_vs_m"}, {31'd0, em_flush_o & m_stall_o}, 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    in_t t;
    in_t lu5;

    lu5 = mk(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs.push_back('{idle(), Z, "idle"});
    vecs.push_back('{lu5, LU, "lu_rs1"});
    vecs.push_back('{mk(0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0, 0), Z, "lu_rd0"});
    vecs.push_back('{mk(0, 5'd3, 5'd5, 1, 1, 5'd5, 1, 0, 0, 0, 0), LU, "lu_rs2"});
    vecs.push_back('{mk(0, 5'd3, 5'd5, 1, 0, 5'd5, 1, 0, 0, 0, 0), Z, "lu_rs2_unused"});
    vecs.push_back('{mk(0, 5'd5, 5'd0, 1, 0, 5'd5, 0, 0, 0, 0, 0), Z, "no_load"});
    vecs.push_back('{mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 0), BR, "branch"});
    vecs.push_back('{mk(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, 0), BR, "branch_over_lu"});
    vecs.push_back('{mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0), MW, "memwait"});
    vecs.push_back('{mk(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 1, 0), MW, "memwait_lu"});
    vecs.push_back('{mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1, 0), MW, "memwait_br"});
    vecs.push_back('{mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1), Z, "mem_ready"});
    vecs.push_back('{mk(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 1, 1), LU, "mem_ready_lu"});

    // Reset: outputs low even with every hazard input active.
    t = mk(1, 5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 1, 1, 0);
    cyc(t, Z, "reset0");
    cyc(t, Z, "reset1");
    cyc(idle(), Z, "after_reset");
`ifdef HAZARD_CTRL_PERF_EN
    check("stall_cnt_reset", stall_cnt_o, 32'd0);
    check("flush_cnt_reset", {16'd0, flush_cnt_o}, 32'd0);
`endif

    foreach (vecs[i]) cyc(vecs[i].in, vecs[i].exp, vecs[i].name);

    // Plain 8-cycle mul/div with start held high to expose any restart.
    cyc(idle(), Z, "pre_mdiv");
`ifdef HAZARD_CTRL_PERF_EN
    sbase = stall_cnt_o;
`endif
    t = idle(); t.md = 1'b1;
    for (int i = 1; i <= 8; i++) cyc(t, MD, $sformatf("mdiv_stall%0d", i));
    cyc(t, DN, "mdiv_done");
`ifdef HAZARD_CTRL_PERF_EN
    check("stall_cnt_mdiv", stall_cnt_o, sbase + 32'd8);
`endif
    cyc(idle(), Z, "mdiv_no_restart");

    // Memory wait for three cycles.
    t = idle(); t.req = 1'b1;
    for (int i = 1; i <= 3; i++) cyc(t, MW, $sformatf("memwait_seq%0d", i));
    t.rdy = 1'b1;
    cyc(t, Z, "memwait_release");

    // mul/div with a memory wait inside it and a branch held during the stall.
`ifdef HAZARD_CTRL_PERF_EN
    fbase = flush_cnt_o;
`endif
    for (int i = 1; i <= 8; i++) begin
      t = idle();
      t.md  = (i == 1);
      t.req = (i == 3 || i == 4);
      t.br  = (i >= 6);
      cyc(t, t.req ? MW : MD, $sformatf("mdiv_mix%0d", i));
    end
    t = idle(); t.br = 1'b1;
    cyc(t, DNBR, "mdiv_mix_done_branch");
`ifdef HAZARD_CTRL_PERF_EN
    check("flush_cnt_branch", {16'd0, flush_cnt_o}, {16'd0, fbase});
`endif
    cyc(idle(), Z, "mdiv_mix_after");
`ifdef HAZARD_CTRL_PERF_EN
    check("flush_cnt_branch_inc", {16'd0, flush_cnt_o}, {16'd0, fbase + 16'd1});
`endif

    // Reset while the counter holds 3: abort with no done pulse.
    t = idle(); t.md = 1'b1;
    cyc(t, MD, "abort_start");
    for (int i = 2; i <= 5; i++) cyc(idle(), MD, $sformatf("abort_stall%0d", i));
    t = idle(); t.rst = 1'b1;
    cyc(t, Z, "abort_reset");
    for (int i = 1; i <= 10; i++) cyc(idle(), Z, $sformatf("abort_after%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MDIV_CYCLES, default 8, legal range 2..15: stall length of a multi-cycle E-stage op.
REQ-002 SHALL have clk_i  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have rst_i  in  1  reset, synchronous, active-high.
REQ-004 SHALL have d_rs1_i, d_rs2_i  in  5 each  D-stage source register numbers.
REQ-005 SHALL have d_rs1_used_i, d_rs2_used_i  in  1 each  D-stage source is actually read.
REQ-006 SHALL have e_rd_i  in  5  E-stage destination register.
REQ-007 SHALL have e_load_i  in  1  E-stage holds a load.
REQ-008 SHALL have e_branch_taken_i  in  1  E-stage branch/jump resolved taken.
REQ-009 SHALL have e_mdiv_start_i  in  1  E-stage holds a multi-cycle mul/div op.
REQ-010 SHALL have m_mem_req_i, m_mem_ready_i  in  1 each  M-stage memory request, memory ready.
REQ-011 SHALL have f_stall_o, d_stall_o, e_stall_o, m_stall_o, w_stall_o  out  1 each  per-stage hold.
REQ-012 SHALL have fd_flush_o, de_flush_o, em_flush_o, mw_flush_o  out  1 each  insert NOP into that pipe register.
REQ-013 SHALL have e_mdiv_done_o  out  1  one-cycle pulse when the mul/div stall ends.

Function
REQ-014 SHALL be a two-state FSM (RUN, MDIV) plus a down-counter mdiv_cnt of $clog2(MDIV_CYCLES) bits; all other outputs are combinational from inputs, state, and counter.
REQ-015 SHALL define mem_wait = m_mem_req_i & ~m_mem_ready_i; while mem_wait, assert f/d/e/m_stall_o and mw_flush_o, and deassert em_flush_o.
REQ-016 SHALL define load_use = e_load_i & (e_rd_i != 0) & ((d_rs1_used_i & d_rs1_i == e_rd_i) | (d_rs2_used_i & d_rs2_i == e_rd_i)); when load_use and not mem_wait, assert f_stall_o, d_stall_o, de_flush_o.
REQ-017 SHALL, in RUN with e_mdiv_start_i and not mem_wait, assert f/d/e_stall_o and em_flush_o, load mdiv_cnt with MDIV_CYCLES-1, and go to MDIV.
REQ-018 SHALL, in MDIV with mdiv_cnt != 0, assert f/d/e_stall_o, decrement mdiv_cnt every cycle even during mem_wait, and assert em_flush_o only when not mem_wait.
REQ-019 SHALL, in MDIV with mdiv_cnt == 0, pulse e_mdiv_done_o, release the E stall, ignore e_mdiv_start_i, and return to RUN; total E stall is exactly MDIV_CYCLES cycles.
REQ-020 SHALL, on e_branch_taken_i when not mem_wait and not stalling E, assert fd_flush_o and de_flush_o with f_stall_o low; a branch held during a stall flushes only in the cycle E is released.
REQ-021 SHALL give branch flush priority over load_use; load_use stall and de_flush_o are suppressed that cycle.
REQ-022 SHALL tie w_stall_o to 0.
REQ-023 SHALL never assert a stall and a flush on the same pipe register's downstream side in conflict: em_flush_o=0 whenever m_stall_o=1.

Reset
REQ-024 SHALL, while rst_i is high at a clock edge, set state RUN and mdiv_cnt 0; with rst_i high, all stall, flush, and e_mdiv_done_o outputs SHALL be 0.
REQ-025 SHALL abort an in-progress MDIV on reset with no e_mdiv_done_o pulse.

Configuration
REQ-026 SHALL, with HAZARD_CTRL_PERF_EN defined, add ports stall_cnt_o (32, cycles with f_stall_o=1) and flush_cnt_o (16, cycles with fd_flush_o=1); both saturate at all-ones and reset to 0.
REQ-027 SHALL, without HAZARD_CTRL_PERF_EN, omit both ports and counters; all other behaviour is identical.

Verification
REQ-028 SHALL cover load-use: e_load_i=1, e_rd_i=5, d_rs1_i=5 used -> f_stall_o=d_stall_o=de_flush_o=1 for 1 cycle; e_rd_i=0 -> no stall.
REQ-029 SHALL cover mul/div: e_mdiv_start_i=1 in RUN, MDIV_CYCLES=8 -> e_stall_o high for exactly 8 cycles, e_mdiv_done_o pulses on cycle 9, no restart.
REQ-030 SHALL cover mem wait: m_mem_req_i=1, m_mem_ready_i=0 for 3 cycles -> f/d/e/m_stall_o=mw_flush_o=1 for those 3 cycles, em_flush_o=0.
REQ-031 SHALL cover branch vs load-use: both present in one cycle -> fd_flush_o=de_flush_o=1, f_stall_o=0.
REQ-032 SHALL cover reset in MDIV: rst_i high at mdiv_cnt=3 -> RUN next cycle, all outputs 0, no done pulse.
REQ-033 SHALL cover perf counters, with HAZARD_CTRL_PERF_EN: 8-cycle mul/div -> stall_cnt_o increases by 8.
